flag_branch_unit: RTL and testbench
===================================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, reset, synchronous and active-high.
REQ-003 The block SHALL have the port `ex_valid`: input, 1 bit, a valid instruction occupies EX this cycle.
REQ-004 The block SHALL have the port `ex_is_alu`: input, 1 bit, the EX instruction is an ALU-class operation.
REQ-005 The block SHALL have the port `ex_alu_op`: input, 3 bits, ALU opcode. Encodings: 000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADDSUB.
REQ-006 The block SHALL have the port `alu_flags`: input, 3 bits, ALU flags for the EX instruction. Bit [2]=Z, [1]=V, [0]=N.
REQ-007 The block SHALL have the port `stall`: input, 1 bit, external pipeline stall; freezes the EX and ID stages.
REQ-008 The block SHALL have the port `flush`: input, 1 bit, squashes the EX and ID instructions this cycle.
REQ-009 The block SHALL have the port `br_valid`: input, 1 bit, a conditional branch occupies ID.
REQ-010 The block SHALL have the port `br_cond`: input, 3 bits, branch condition code.
REQ-011 The block SHALL have the port `flags_q`: output, 3 bits, architectural flag register {Z,V,N}.
REQ-012 The block SHALL have the port `flag_stall`: output, 1 bit, combinational request to hold ID for one cycle.
REQ-013 The block SHALL have the port `br_done`: output, 1 bit, registered pulse; a branch resolved last cycle.
REQ-014 The block SHALL have the port `br_taken`: output, 1 bit, registered; the resolution result, meaningful only when `br_done`=1.

Function
REQ-015 The flag write-mask `wmask` SHALL be derived from `ex_alu_op` when `ex_valid`&`ex_is_alu`, as follows:
- ADD/SUB: mask 111, updating Z, V and N.
- XOR/SLL/SRA/ROR: mask 100, updating Z only.
- RED/PADDSUB: mask 000.
- Non-ALU or invalid instruction: mask 000.
REQ-016 On each rising edge with `stall`=0 and `flush`=0, each bit of `flags_q` SHALL load the corresponding bit of `alu_flags` if its `wmask` bit is 1, and SHALL otherwise hold.
REQ-017 When `stall`=1 or `flush`=1, `flags_q` SHALL hold.
REQ-018 `flag_stall` SHALL equal `br_valid` & `ex_valid` & `ex_is_alu` & (`wmask`!=000) & !`flush`, so a branch never evaluates stale flags.
REQ-019 A branch SHALL resolve on the edge where `br_valid`=1, `flag_stall`=0, `stall`=0 and `flush`=0; resolution SHALL use `flags_q` as it stood before that edge.
REQ-020 On a resolving edge, `br_done` SHALL be set to 1 and `br_taken` SHALL be set to cond(`br_cond`, `flags_q`). On all other edges, `br_done` SHALL be set to 0 and `br_taken` SHALL be set to 0.
REQ-021 The condition table SHALL be:
- 000 NE: !Z
- 001 EQ: Z
- 010 GT: !Z & !N
- 011 LT: N
- 100 GE: Z | (!Z & !N)
- 101 LE: N | Z
- 110 OV: V
- 111 UN: 1
REQ-022 Resolution latency SHALL be as follows:
- No flag hazard: `br_done` is 1 exactly one cycle after the branch is presented.
- Flag hazard: `br_done` is 1 exactly two cycles after the branch is presented, the first cycle being spent in `flag_stall`.
REQ-023 A branch held in ID across consecutive stalled cycles SHALL resolve once only, because resolution requires `stall`=0.
REQ-024 `flush` SHALL take priority over `stall`: no flag update and no resolution occur, and `br_done` is set to 0 on that edge.
REQ-025 `stall` and `flag_stall` asserted together SHALL behave as `stall`.

Reset
REQ-026 On a rising edge with `rst`=1, `flags_q` SHALL be set to 000, `br_done` to 0 and `br_taken` to 0, overriding all other inputs including `flush` and `stall`.
REQ-027 A branch pending during reset SHALL be discarded, producing no `br_done` pulse after `rst` deasserts.
REQ-028 While `rst`=1, `flag_stall` SHALL still follow REQ-018, being combinational.

Verification
REQ-029 The bench SHALL cover ADD with `alu_flags`=011, then XOR with `alu_flags`=100: `flags_q` = 011 after the ADD edge and 111 after the XOR edge, with V and N held.
REQ-030 The bench SHALL cover `flags_q`=100 with an EQ branch presented and no EX instruction: `flag_stall`=0, and on the next cycle `br_done`=1, `br_taken`=1.
REQ-031 The bench SHALL cover an SUB in EX producing 001 while a GT branch is in ID (old `flags_q`=000): the sequence is:
- Cycle 0: `flag_stall`=1.
- Cycle 1: `flags_q`=001 and the branch resolves.
- Cycle 2: `br_done`=1, `br_taken`=0.
REQ-032 The bench SHALL cover RED and PADDSUB with `alu_flags`=111 while `flags_q`=010: `flags_q` stays 010, and an OV branch presented alongside produces no `flag_stall` and resolves with `br_taken`=1.
REQ-033 The bench SHALL cover `stall`=1 for 3 cycles with a UN branch in ID, then `stall`=0: exactly one `br_done` pulse, with `br_taken`=1.
REQ-034 The bench SHALL cover `flush`=1 coincident with ADD (`alu_flags`=111) and an NE branch, followed by `rst`=1 mid-run: the flush edge gives no flag change and `br_done`=0; the reset edge gives `flags_q`=000 and no residual `br_done`.

Source files
------------

// File: rtl/flag_branch_unit.sv
// Flag register with per-op write masks plus conditional-branch resolution.
// Branches in ID wait one cycle on an in-flight flag writer in EX so they never read stale flags.
module flag_branch_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic       ex_is_alu,
    input  logic [2:0] ex_alu_op,
    input  logic [2:0] alu_flags,
    input  logic       stall,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    output logic [2:0] flags_q,
    output logic       flag_stall,
    output logic       br_done,
    output logic       br_taken
);

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_XOR     = 3'b010;
    localparam logic [2:0] OP_SLL     = 3'b100;
    localparam logic [2:0] OP_SRA     = 3'b101;
    localparam logic [2:0] OP_ROR     = 3'b110;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;

    logic [2:0] wmask;
    logic       resolve;
    logic       cond_met;
    logic       flag_z;
    logic       flag_v;
    logic       flag_n;

    assign flag_z = flags_q[2];
    assign flag_v = flags_q[1];
    assign flag_n = flags_q[0];

    always_comb begin
        wmask = 3'b000;
        if (ex_valid && ex_is_alu) begin
            case (ex_alu_op)
                OP_ADD, OP_SUB:                 wmask = 3'b111;
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: wmask = 3'b100;
                default:                        wmask = 3'b000;
            endcase
        end
    end

    always_comb begin
        cond_met = 1'b1;
        case (br_cond)
            CC_NE:   cond_met = !flag_z;
            CC_EQ:   cond_met = flag_z;
            CC_GT:   cond_met = !flag_z && !flag_n;
            CC_LT:   cond_met = flag_n;
            CC_GE:   cond_met = flag_z || (!flag_z && !flag_n);
            CC_LE:   cond_met = flag_n || flag_z;
            CC_OV:   cond_met = flag_v;
            default: cond_met = 1'b1;
        endcase
    end

    // Only a writer that actually touches flags forces the branch to wait.
    assign flag_stall = br_valid && ex_valid && ex_is_alu && (wmask != 3'b000) && !flush;
    assign resolve    = br_valid && !flag_stall && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q  <= 3'b000;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            if (!stall && !flush) begin
                flags_q <= (flags_q & ~wmask) | (alu_flags & wmask);
            end
            br_done  <= resolve;
            br_taken <= resolve && cond_met;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed and randomized checks of flag_branch_unit against a bit-level behavioural model.
module tb_flag_branch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid;
    logic       ex_is_alu;
    logic [2:0] ex_alu_op;
    logic [2:0] alu_flags;
    logic       stall;
    logic       flush;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [2:0] flags_q;
    logic       flag_stall;
    logic       br_done;
    logic       br_taken;

    int checks   = 0;
    int failures = 0;

    logic m_z, m_v, m_n;
    logic m_done, m_taken;

    flag_branch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_is_alu  (ex_is_alu),
        .ex_alu_op  (ex_alu_op),
        .alu_flags  (alu_flags),
        .stall      (stall),
        .flush      (flush),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .flags_q    (flags_q),
        .flag_stall (flag_stall),
        .br_done    (br_done),
        .br_taken   (br_taken)
    );

    always #5 clk = ~clk;

    // Which of Z, V, N the EX instruction writes.
    function automatic void writes(input logic v, input logic a, input int op,
                                   output logic wz, output logic wv, output logic wn);
        wz = 0; wv = 0; wn = 0;
        if (v && a) begin
            if (op == 0 || op == 1) begin wz = 1; wv = 1; wn = 1; end
            else if (op == 2 || op == 4 || op == 5 || op == 6) wz = 1;
        end
    endfunction

    function automatic logic taken_of(input int c, input logic z, input logic v, input logic n);
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || (!z && !n);
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs, check combinational stall, clock, check registered state.
    task automatic step(input logic v, input logic a, input int op, input logic [2:0] fl,
                        input logic st, input logic fs, input logic bv, input int bc,
                        input logic r);
        logic wz, wv, wn, exp_fs, res;
        ex_valid = v; ex_is_alu = a; ex_alu_op = 3'(op); alu_flags = fl;
        stall = st; flush = fs; br_valid = bv; br_cond = 3'(bc); rst = r;
        writes(v, a, op, wz, wv, wn);
        exp_fs = bv && (wz || wv || wn) && !fs;
        #1;
        check("flag_stall", {2'b0, flag_stall}, {2'b0, exp_fs});
        @(posedge clk);
        if (r) begin
            m_z = 0; m_v = 0; m_n = 0; m_done = 0; m_taken = 0;
        end else begin
            res     = bv && !exp_fs && !st && !fs;
            m_taken = res && taken_of(bc, m_z, m_v, m_n);
            m_done  = res;
            if (!st && !fs) begin
                if (wz) m_z = fl[2];
                if (wv) m_v = fl[1];
                if (wn) m_n = fl[0];
            end
        end
        #1;
        check("flags_q", flags_q, {m_z, m_v, m_n});
        check("br_done", {2'b0, br_done}, {2'b0, m_done});
        check("br_taken", {2'b0, br_taken}, {2'b0, m_taken});
    endtask

    initial begin
        m_z = 0; m_v = 0; m_n = 0; m_done = 0; m_taken = 0;
        // reset, with a flag writer and branch present to exercise combinational stall under rst
        step(1, 1, 0, 3'b111, 1, 1, 1, 0, 1);
        check("reset_flags", flags_q, 3'b000);

        // ADD 011 then XOR 100
        step(1, 1, 0, 3'b011, 0, 0, 0, 0, 0);
        check("add_flags", flags_q, 3'b011);
        step(1, 1, 2, 3'b100, 0, 0, 0, 0, 0);
        check("xor_flags", flags_q, 3'b111);

        // flags=100, EQ branch, no EX instruction
        step(0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
        step(1, 1, 2, 3'b100, 0, 0, 0, 0, 0);
        check("eq_setup", flags_q, 3'b100);
        step(0, 0, 0, 3'b000, 0, 0, 1, 1, 0);
        check("eq_taken", {br_done, br_taken}, 3'b011);

        // SUB 001 with GT branch over old flags 000: hazard then resolve
        step(0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
        step(1, 1, 1, 3'b001, 0, 0, 1, 2, 0);
        check("gt_hold_done", {2'b0, br_done}, 3'b000);
        check("gt_new_flags", flags_q, 3'b001);
        step(0, 0, 0, 3'b000, 0, 0, 1, 2, 0);
        check("gt_resolved", {br_done, br_taken}, 3'b010);

        // RED / PADDSUB leave flags=010; OV branches resolve taken without stall
        step(1, 1, 0, 3'b010, 0, 0, 0, 0, 0);
        step(1, 1, 3, 3'b111, 0, 0, 1, 6, 0);
        check("red_ov", {br_done, br_taken, flags_q[1]}, 3'b111);
        step(1, 1, 7, 3'b111, 0, 0, 1, 6, 0);
        check("paddsub_hold", flags_q, 3'b010);

        // UN branch held through 3 stalled cycles, resolving once
        for (int i = 0; i < 3; i++) step(1, 1, 0, 3'b101, 1, 0, 1, 7, 0);
        check("stall_no_done", {2'b0, br_done}, 3'b000);
        step(0, 0, 0, 3'b000, 0, 0, 1, 7, 0);
        check("un_once", {br_done, br_taken}, 3'b011);
        step(0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        check("un_single_pulse", {2'b0, br_done}, 3'b000);

        // flush with ADD and NE branch, then reset with a pending branch
        step(1, 1, 0, 3'b111, 1, 1, 1, 0, 0);
        check("flush_flags", flags_q, 3'b010);
        step(0, 0, 0, 3'b000, 0, 0, 1, 0, 1);
        check("rst_flags", flags_q, 3'b000);
        step(0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        check("rst_no_done", {2'b0, br_done}, 3'b000);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 $urandom_range(0, 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
